// File: rtl/jt51_acc_mix.sv
// Operator output accumulator and stereo mixer: sums each channel's carriers and mixes them into one left/right sample per 32-slot frame.
// Optional build macro JT51_MIX_SAT_EN clamps the outputs to 16 bits; without it the outputs wrap.
module jt51_acc_mix (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               zero,
  input  logic signed [13:0] op_XVII,
  input  logic        [2:0]  con,
  input  logic        [1:0]  rl,
  output logic signed [15:0] left,
  output logic signed [15:0] right,
  output logic               sample
);

  localparam int NCH = 8;

  logic        [4:0]  slot_q, slot_d, cur_slot;
  logic        [1:0]  op_sel;
  logic        [3:0]  mask;
  logic               synced_q, synced_d;
  logic signed [15:0] acc_q [NCH];
  logic signed [15:0] acc_d [NCH];
  logic signed [15:0] contrib, acc_new, chan_sum;
  logic signed [18:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic signed [18:0] gated_l, gated_r, fin_l, fin_r;
  logic signed [15:0] left_q, left_d, right_q, right_d;
  logic               sample_q, sample_d;

  function automatic logic signed [15:0] to_out(input logic signed [18:0] v);
`ifdef JT51_MIX_SAT_EN
    if (v > 19'sd32767)       return 16'sh7FFF;
    else if (v < -19'sd32768) return 16'sh8000;
    else                      return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    // zero marks the slot-0 sample on the current cycle, so it overrides the counter immediately.
    cur_slot = zero ? 5'd0 : slot_q;
    op_sel   = cur_slot[4:3];

    case (con)
      3'd4:       mask = 4'b1100;
      3'd5, 3'd6: mask = 4'b1110;
      3'd7:       mask = 4'b1111;
      default:    mask = 4'b1000;
    endcase

    contrib  = mask[op_sel] ? {{2{op_XVII[13]}}, op_XVII} : 16'sd0;
    chan_sum = acc_q[NCH-1] + contrib;
    acc_new  = (op_sel == 2'd0) ? contrib : chan_sum;
    gated_l  = rl[1] ? {{3{chan_sum[15]}}, chan_sum} : 19'sd0;
    gated_r  = rl[0] ? {{3{chan_sum[15]}}, chan_sum} : 19'sd0;
    fin_l    = mix_l_q + gated_l;
    fin_r    = mix_r_q + gated_r;

    slot_d   = slot_q;
    synced_d = synced_q;
    acc_d    = acc_q;
    mix_l_d  = mix_l_q;
    mix_r_d  = mix_r_q;
    left_d   = left_q;
    right_d  = right_q;
    sample_d = 1'b0;

    if (cen) begin
      slot_d   = cur_slot + 5'd1;
      synced_d = synced_q | zero;
      acc_d[0] = acc_new;
      for (int i = 1; i < NCH; i++) acc_d[i] = acc_q[i-1];
      if (op_sel == 2'd3) begin
        mix_l_d = (cur_slot[2:0] == 3'd0) ? gated_l : fin_l;
        mix_r_d = (cur_slot[2:0] == 3'd0) ? gated_r : fin_r;
      end
      if (cur_slot == 5'd31 && synced_q) begin
        left_d   = to_out(fin_l);
        right_d  = to_out(fin_r);
        sample_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      synced_q <= 1'b0;
      // NOTE: the channel shift register is reset too; a stale partial sum would otherwise leak into the first frame.
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
      mix_l_q  <= '0;
      mix_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      synced_q <= synced_d;
      acc_q    <= acc_d;
      mix_l_q  <= mix_l_d;
      mix_r_q  <= mix_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      sample_q <= sample_d;
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;

endmodule
